// File: rtl/pipelined_addsub_pkg.sv
// Shared constants for pipelined_addsub: bit positions used when a consumer packs
// the status flags as {ovf, zero, cout}.
package pipelined_addsub_pkg;

  localparam int unsigned FlagCout = 0;
  localparam int unsigned FlagZero = 1;
  localparam int unsigned FlagOvf  = 2;
  localparam int unsigned NumFlags = 3;

endpackage

// File: rtl/addsub_slice.sv
// Combinational ripple-carry slice; also exposes the carry into its MSB so the
// top slice can derive signed overflow.
module addsub_slice #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [WIDTH:0] carry;

  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[WIDTH];
  assign cmsb = carry[WIDTH-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: one carry-chained slice per stage, operand skew and
// sum deskew carried in the stage registers, valid/ready with bubble collapsing.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SLICE = WIDTH / STAGES;
  localparam int unsigned Last  = STAGES - 1;

  if (STAGES < 1) begin : g_stages_err
    $error("pipelined_addsub: STAGES must be at least 1");
  end else if (WIDTH % STAGES != 0) begin : g_width_err
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;

  // b_q holds the already-inverted operand in subtract mode.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];

  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [WIDTH-1:0]  s_nxt [STAGES];
  logic [STAGES-1:0] c_src;
  logic [SLICE-1:0]  slice_sum [STAGES];
  logic [STAGES-1:0] slice_cout;
  logic              slice_cmsb [STAGES];

  logic [NumFlags-1:0] flags_d, flags_q;

  // Ready propagates from out_ready down to stage 0; a stage advances when the
  // stage above it is empty or advancing itself.
  always_comb begin : p_ready
    logic down_ok;
    adv      = '0;
    down_ok  = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]  = valid_q[k] && down_ok;
      down_ok = !valid_q[k] || down_ok;
    end
    in_ready = down_ok;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_src[k] = a;
      assign b_src[k] = sub ? ~b : b;
      assign s_src[k] = '0;
      assign c_src[k] = cin ^ sub;
      assign load[k]  = in_valid && in_ready;
    end else begin : g_body
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign s_src[k] = s_q[k-1];
      assign c_src[k] = c_q[k-1];
      assign load[k]  = adv[k-1];
    end

    addsub_slice #(
      .WIDTH(SLICE)
    ) u_slice (
      .a    (a_src[k][k*SLICE +: SLICE]),
      .b    (b_src[k][k*SLICE +: SLICE]),
      .cin  (c_src[k]),
      .sum  (slice_sum[k]),
      .cout (slice_cout[k]),
      .cmsb (slice_cmsb[k])
    );

    // Lower slices pass through; this stage's slice is merged in place.
    assign s_nxt[k] = (s_src[k] & ~(WIDTH'({SLICE{1'b1}}) << (k * SLICE))) |
                      (WIDTH'(slice_sum[k]) << (k * SLICE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          a_q[k]     <= a_src[k];
          b_q[k]     <= b_src[k];
          s_q[k]     <= s_nxt[k];
          c_q[k]     <= slice_cout[k];
        end else if (adv[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    flags_d           = '0;
    flags_d[FlagCout] = slice_cout[Last];
    flags_d[FlagOvf]  = slice_cout[Last] ^ slice_cmsb[Last];
    flags_d[FlagZero] = (s_nxt[Last] == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (load[Last]) begin
      flags_q <= flags_d;
    end
  end

  assign out_valid = valid_q[Last];
  assign sum       = s_q[Last];
  assign cout      = flags_q[FlagCout];
  assign ovf       = flags_q[FlagOvf];
  assign zero      = flags_q[FlagZero];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=16, STAGES=4): latency, flags,
// streaming with backpressure, and mid-flight reset.
module tb_pipelined_addsub;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;
  localparam int unsigned NBeats = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf, zero;

  int n_checks;
  int n_fail;

  logic [W-1:0] va [NBeats];
  logic [W-1:0] vb [NBeats];
  logic         vc [NBeats];
  logic         vs [NBeats];

  always #5 clk = ~clk;

  pipelined_addsub #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference: returns {cout, ovf, zero, sum}.
  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W-1:0] ye;
    logic [W:0]   r;
    logic         o;
    ye = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + (W+1)'(c ^ s);
    o  = (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]);
    return {r[W], o, (r[W-1:0] == '0), r[W-1:0]};
  endfunction

  task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic ts, input logic [W-1:0] esum,
                         input logic ecout, input logic eovf, input logic ezero);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    #1 check_eq({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      #1 check_eq({tag, "_early"}, out_valid, 0);
      @(negedge clk);
    end
    #1;
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_sum"}, sum, esum);
    check_eq({tag, "_cout"}, cout, ecout);
    check_eq({tag, "_ovf"}, ovf, eovf);
    check_eq({tag, "_zero"}, zero, ezero);
    @(negedge clk);
    #1 check_eq({tag, "_drain"}, out_valid, 0);
  endtask

  task automatic run_stream(input string tag, input int stall_start, input int stall_len,
                            input int exp_last);
    int           sent, rcvd, last_it;
    logic         hold;
    logic [W+3:0] snap;
    sent = 0; rcvd = 0; last_it = -1; hold = 1'b0; snap = '0;
    for (int it = 0; it < 80 && rcvd < int'(NBeats); it++) begin
      @(negedge clk);
      out_ready = !(it >= stall_start && it < stall_start + stall_len);
      in_valid  = (sent < int'(NBeats));
      if (sent < int'(NBeats)) begin
        a = va[sent]; b = vb[sent]; cin = vc[sent]; sub = vs[sent];
      end
      #1;
      if (hold) check_eq({tag, "_hold"}, {out_valid, cout, ovf, zero, sum}, snap);
      check_eq({tag, "_in_ready"}, in_ready, !((sent - rcvd) == int'(S) && !out_ready));
      snap = {out_valid, cout, ovf, zero, sum};
      hold = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        check_eq({tag, "_res"}, {cout, ovf, zero, sum},
                 model(va[rcvd], vb[rcvd], vc[rcvd], vs[rcvd]));
        rcvd++;
        last_it = it;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    check_eq({tag, "_count"}, rcvd, NBeats);
    check_eq({tag, "_last_cycle"}, last_it, exp_last);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < int'(NBeats); i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
      vc[i] = 1'($urandom);
      vs[i] = 1'($urandom);
    end

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_flags", {cout, ovf, zero}, 0);
    rst_n = 1'b1;
    #1 check_eq("rst_in_ready", in_ready, 1);

    run_one("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_one("add_cin",   16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b0);
    run_one("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    run_stream("stream", 0, 0, 23);
    run_stream("stall", 8, 6, 29);

    // Three beats in flight, then reset.
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'h1111 * 16'(i + 1); b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_sum", sum, 0);
    check_eq("midrst_flags", {cout, ovf, zero}, 0);
    rst_n = 1'b1;
    #1 check_eq("midrst_in_ready", in_ready, 1);
    repeat (5) begin
      @(negedge clk);
      #1 check_eq("midrst_flushed", out_valid, 0);
    end
    run_one("post_rst", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
